lstm_h_pingpong: RTL and testbench
==================================

# lstm_h_pingpong

Parametrised double-buffered hidden-state store for the LSTM layer. It generalises the two fixed H buffers and their select logic into one block. Each cycle it accepts a group of `UNITS_NUM` h values from the layer into the write bank. It serves per-cell reads of the previous timestep from the read bank. It swaps banks at the end of each timestep, and can stream the whole read bank to the fully-connected stage over a valid/ready handshake.

## Interface
Parameters:
- `D_WL`, 24, data word length
- `UNITS_NUM`, 5, cells per write group
- `ALL_CELL_NUM`, 30, cells per bank; must be a multiple of `UNITS_NUM`; `GROUPS = ALL_CELL_NUM/UNITS_NUM`
- `ADDR_W`, 8, address width; `2**ADDR_W >= ALL_CELL_NUM`

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `seq_rst`  in  1  synchronous sequence clear (highest priority)
- `wr_valid`  in  1  write group strobe
- `wr_addr`  in  ADDR_W  group index, 0..GROUPS-1
- `wr_data`  in  D_WL*UNITS_NUM  unit u at bits [u*D_WL +: D_WL]
- `step_done`  in  1  end-of-timestep pulse; requests a bank swap
- `rd_en`  in  1  random read strobe
- `rd_addr`  in  ADDR_W  cell index, 0..ALL_CELL_NUM-1
- `rd_data`  out  D_WL  registered read data
- `rd_valid`  out  1  `rd_data` valid
- `drain_start`  in  1  start streaming the read bank
- `drain_ready`  in  1  downstream accept
- `drain_valid`  out  1  `drain_data` valid
- `drain_data`  out  D_WL  streamed cell value
- `drain_busy`  out  1  drain in progress
- `drain_done`  out  1  one-cycle pulse after the last cell is accepted
- `bank_sel`  out  1  0 means write bank 0 and read bank 1; 1 means the reverse
- `err`  out  1  sticky error flag

## Operation
- Cell index `c = group*UNITS_NUM + u`.
- **Write:** when `wr_valid` is high, all UNITS_NUM words are stored to the write bank at `wr_addr` in a single cycle.
  - If `wr_addr >= GROUPS`, the write is dropped and `err` is set.
- **Read:** `rd_en` reads cell `rd_addr` of the read bank.
  - If `rd_addr >= ALL_CELL_NUM`, `rd_data` = 0 and `err` is set.
- **Swap:** `step_done` toggles `bank_sel`.
  - A write and `step_done` in the same cycle: the write lands in the pre-swap write bank.
- **Drain FSM**, with states IDLE, DRAIN, SWAP_PEND:
  - IDLE → DRAIN on `drain_start`. The cell counter is cleared to 0.
  - In DRAIN, `drain_data` = read bank[counter]. The counter advances on `drain_valid & drain_ready`. Data is held stable while `drain_ready` is low.
  - After cell ALL_CELL_NUM-1 is accepted, the FSM returns to IDLE and pulses `drain_done`.
  - `step_done` during DRAIN is deferred. A pending flag is set and the swap is applied in the cycle after `drain_done`. The drain always reads one consistent bank.
  - A second `step_done` while a swap is already pending sets `err`; the swaps do not accumulate.
  - `drain_start` while busy is ignored.
- **`seq_rst`:**
  - zeroes both banks
  - sets `bank_sel` = 0
  - aborts any drain, with no `drain_done` pulse
  - clears the pending swap and `err`
  - overrides all other inputs in that cycle
- **Reset:** `rst_n` low gives the same state as `seq_rst`. All outputs are 0.

## Timing
- Write: data is readable from the read bank the cycle after the `step_done` that swaps it in.
- Read latency: 1 cycle. `rd_valid` equals `rd_en` delayed by one cycle.
- Drain:
  - `drain_valid` rises the cycle after `drain_start`. `drain_busy` rises in the same cycle.
  - With `drain_ready` held high, the drain takes ALL_CELL_NUM consecutive beats.
  - `drain_done` occurs one cycle after the last beat.
  - `drain_busy` falls in the same cycle as the `drain_done` pulse.
- Swap: `bank_sel` changes the cycle after `step_done` is sampled, or the cycle after `drain_done` if the swap was deferred.
- Reads with `rd_en` in the same cycle as a swap use the pre-swap read bank.
- `err` is set the cycle after the offending event.

## Configuration
- `LSTM_H_DRAIN_EN`:
  - **Defined:** the drain FSM and handshake are present as specified above.
  - **Undefined:** `drain_start` and `drain_ready` are ignored. `drain_valid`, `drain_data`, `drain_busy` and `drain_done` are tied to 0. `step_done` always swaps immediately.

## Test plan
1. **Write, swap, read:** write groups 0..5 with cell c = c+1, then pulse `step_done`, then read cells 0, 7 and 29. Expect `rd_data` = 1, 8, 30 one cycle later each, and `bank_sel` = 1.
2. **Drain with back-pressure:** after test 1, start a drain and hold `drain_ready` low on beats 3 and 4. Expect:
   - 30 beats with values 1..30 in order
   - `drain_data` = 4 held stable during the stall
   - a single `drain_done` pulse
3. **Deferred swap:** pulse `step_done` at beat 10 of a drain. Expect `bank_sel` to stay unchanged until the cycle after `drain_done`, then toggle. Beats 11..30 continue from the old bank.
4. **Out-of-range addresses:** write with `wr_addr` = 6, or read with `rd_addr` = 30. Expect the bank contents unchanged, `rd_data` = 0 and `err` = 1. A following `seq_rst` clears `err` to 0.
5. **Abort:** assert `seq_rst` mid-drain at beat 5. Expect the next cycle to show `drain_valid` = 0, `drain_busy` = 0 and no `drain_done`. All reads then return 0 and `bank_sel` = 0.
6. **Same-cycle write and swap:** `wr_valid` (group 2 = 7s) with `step_done` in the same cycle. Expect a read of cell 10 after the swap to return 7.

Source files
------------

// File: rtl/lstm_h_pingpong.sv
// Double-buffered LSTM hidden-state store: group writes, random reads, bank swap per timestep.
// The streaming drain FSM is built only when LSTM_H_DRAIN_EN is defined.
module lstm_h_pingpong #(
    parameter int D_WL         = 24,
    parameter int UNITS_NUM    = 5,
    parameter int ALL_CELL_NUM = 30,
    parameter int ADDR_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seq_rst,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [D_WL*UNITS_NUM-1:0] wr_data,
    input  logic                      step_done,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [D_WL-1:0]           rd_data,
    output logic                      rd_valid,
    input  logic                      drain_start,
    input  logic                      drain_ready,
    output logic                      drain_valid,
    output logic [D_WL-1:0]           drain_data,
    output logic                      drain_busy,
    output logic                      drain_done,
    output logic                      bank_sel,
    output logic                      err
);
    localparam int GROUPS = ALL_CELL_NUM / UNITS_NUM;
    localparam int CW     = (ALL_CELL_NUM > 1) ? $clog2(ALL_CELL_NUM) : 1;
    localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(ALL_CELL_NUM);
    localparam logic [ADDR_W-1:0] GROUPS_A = ADDR_W'(GROUPS);

    logic [D_WL-1:0] mem [2][ALL_CELL_NUM];
    logic            swap_now;
    logic            swap_err;
    logic            wr_err;
    logic            rd_ok;

    assign rd_ok  = rd_addr < CELLS_A;
    assign wr_err = wr_valid && (wr_addr >= GROUPS_A);

    // Write bank is mem[bank_sel], read bank is mem[~bank_sel].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < ALL_CELL_NUM; c++) begin
                mem[0][c] <= '0;
                mem[1][c] <= '0;
            end
            bank_sel <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else if (seq_rst) begin
            for (int unsigned c = 0; c < ALL_CELL_NUM; c++) begin
                mem[0][c] <= '0;
                mem[1][c] <= '0;
            end
            bank_sel <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < ALL_CELL_NUM; c++) begin
                if (wr_valid && wr_addr == ADDR_W'(c / UNITS_NUM))
                    mem[bank_sel][c] <= wr_data[(c % UNITS_NUM)*D_WL +: D_WL];
            end
            if (swap_now)
                bank_sel <= ~bank_sel;
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_ok ? mem[~bank_sel][rd_addr[CW-1:0]] : '0;
            if (wr_err || (rd_en && !rd_ok) || swap_err)
                err <= 1'b1;
        end
    end

`ifdef LSTM_H_DRAIN_EN
    typedef enum logic [1:0] {IDLE, DRAIN, SWAP_PEND} state_t;

    state_t          state, state_nx;
    logic            pend, pend_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= 1'b0;
            cnt        <= '0;
            drain_done <= 1'b0;
        end else if (seq_rst) begin
            state      <= IDLE;
            pend       <= 1'b0;
            cnt        <= '0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            cnt        <= cnt_nx;
            drain_done <= done_nx;
        end
    end

    // A swap requested mid-drain is parked and applied from SWAP_PEND, the drain_done cycle.
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        swap_now = 1'b0;
        swap_err = 1'b0;
        case (state)
            IDLE: begin
                swap_now = step_done;
                if (drain_start) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end
            end
            DRAIN: begin
                if (step_done) begin
                    if (pend) swap_err = 1'b1;
                    else      pend_nx  = 1'b1;
                end
                if (drain_ready) begin
                    if (cnt == CW'(ALL_CELL_NUM - 1)) begin
                        done_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = (pend || step_done) ? SWAP_PEND : IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            SWAP_PEND: begin
                swap_now = 1'b1;
                swap_err = step_done;
                pend_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign drain_valid = (state == DRAIN);
    assign drain_busy  = (state == DRAIN);
    assign drain_data  = drain_valid ? mem[~bank_sel][cnt] : '0;
`else
    logic unused_drain;

    assign unused_drain = drain_start ^ drain_ready;
    assign swap_now     = step_done;
    assign swap_err     = 1'b0;
    assign drain_valid  = 1'b0;
    assign drain_data   = '0;
    assign drain_busy   = 1'b0;
    assign drain_done   = 1'b0;
`endif

endmodule

// File: tb/tb_lstm_h_pingpong.sv
// Scoreboard bench for lstm_h_pingpong: read and drain responses are queued at issue
// time and checked by a monitor when rd_valid / drain_valid appear.
module tb_lstm_h_pingpong;
    localparam int D_WL   = 24;
    localparam int UNITS  = 5;
    localparam int ALL    = 30;
    localparam int ADDR_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  seq_rst = 1'b0;
    logic                  wr_valid = 1'b0;
    logic [ADDR_W-1:0]     wr_addr = '0;
    logic [D_WL*UNITS-1:0] wr_data = '0;
    logic                  step_done = 1'b0;
    logic                  rd_en = 1'b0;
    logic [ADDR_W-1:0]     rd_addr = '0;
    logic [D_WL-1:0]       rd_data;
    logic                  rd_valid;
    logic                  drain_start = 1'b0;
    logic                  drain_ready = 1'b0;
    logic                  drain_valid;
    logic [D_WL-1:0]       drain_data;
    logic                  drain_busy;
    logic                  drain_done;
    logic                  bank_sel;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [D_WL-1:0] rd_q[$];
    logic [D_WL-1:0] dr_q[$];

    lstm_h_pingpong #(
        .D_WL(D_WL), .UNITS_NUM(UNITS), .ALL_CELL_NUM(ALL), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seq_rst(seq_rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .step_done(step_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .drain_start(drain_start), .drain_ready(drain_ready),
        .drain_valid(drain_valid), .drain_data(drain_data),
        .drain_busy(drain_busy), .drain_done(drain_done),
        .bank_sel(bank_sel), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got data %0d with no read pending", rd_data);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
            if (drain_valid) begin
                if (dr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drain_unexpected: got beat %0d with none expected", drain_data);
                end else begin
                    check("drain_data", drain_data, dr_q[0]);
                    if (drain_ready) void'(dr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wg(input int g, input int base, input int stride, input logic with_step);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(g);
        for (int u = 0; u < UNITS; u++)
            wr_data[u*D_WL +: D_WL] = D_WL'(base + stride * (g * UNITS + u));
        step_done = with_step;
        tick();
        wr_valid  = 1'b0;
        step_done = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int g = 0; g < ALL / UNITS; g++) wg(g, base, 1, 1'b0);
    endtask

    task automatic rd(input int addr, input int exp);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        rd_q.push_back(D_WL'(exp));
        tick();
        rd_en = 1'b0;
    endtask

    task automatic step();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
    endtask

    task automatic pulse_seq_rst();
        seq_rst = 1'b1;
        tick();
        seq_rst = 1'b0;
    endtask

    task automatic drain(input int stall_at, input int step_at, input int step2_at,
                         input int abort_at, input logic sel_before);
        int   acc = 0;
        int   st  = 0;
        logic deferred = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("drain_busy_rise", drain_busy, 1);
        check("drain_valid_rise", drain_valid, 1);
        while (acc < ALL) begin
            if (acc == abort_at) begin
                check("pend_double_err", err, (step2_at >= 0 && step2_at < acc) ? 32'd1 : 32'd0);
                drain_ready = 1'b0;
                pulse_seq_rst();
                check("abort_valid", drain_valid, 0);
                check("abort_busy", drain_busy, 0);
                check("abort_done", drain_done, 0);
                check("abort_bank_sel", bank_sel, 0);
                check("abort_err", err, 0);
                dr_q.delete();
                tick();
                check("abort_no_done", drain_done, 0);
                check("abort_no_swap", bank_sel, 0);
                return;
            end
            drain_ready = !(acc == stall_at && st < 2);
            if (!drain_ready) st++;
            step_done = drain_ready && (acc == step_at || acc == step2_at);
            if (step_done) deferred = 1'b1;
            tick();
            step_done = 1'b0;
            if (drain_ready) acc++;
            check("drain_bank_sel_hold", bank_sel, sel_before);
        end
        drain_ready = 1'b0;
        check("drain_done_pulse", drain_done, 1);
        check("drain_busy_fall", drain_busy, 0);
        check("drain_valid_fall", drain_valid, 0);
        tick();
        check("drain_done_single", drain_done, 0);
        check("drain_swap_after", bank_sel, deferred ? ~sel_before : sel_before);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_bank_sel", bank_sel, 0);
        check("rst_err", err, 0);
        check("rst_drain_valid", drain_valid, 0);
        check("rst_drain_busy", drain_busy, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_drain_data", drain_data, 0);

        // Test 1: write, swap, read
        fill(1);
        step();
        check("t1_bank_sel", bank_sel, 1);
        rd(0, 1);
        rd(7, 8);
        rd(29, 30);

`ifdef LSTM_H_DRAIN_EN
        // Test 2: drain with a two-cycle stall on the value-4 beat
        for (int c = 0; c < ALL; c++) dr_q.push_back(D_WL'(c + 1));
        drain(3, -1, -1, -1, 1'b1);
        check("t2_queue_empty", dr_q.size(), 0);

        // Test 3: swap deferred from beat 10
        fill(101);
        for (int c = 0; c < ALL; c++) dr_q.push_back(D_WL'(c + 1));
        drain(-1, 9, -1, -1, 1'b1);
        check("t3_queue_empty", dr_q.size(), 0);
`else
        drain_start = 1'b1;
        drain_ready = 1'b1;
        tick();
        check("tie_drain_valid", drain_valid, 0);
        check("tie_drain_busy", drain_busy, 0);
        check("tie_drain_data", drain_data, 0);
        drain_start = 1'b0;
        tick();
        drain_ready = 1'b0;
        check("tie_drain_done", drain_done, 0);
        fill(101);
        step();
        check("t3_swap_immediate", bank_sel, 0);
`endif
        check("t3_bank_sel", bank_sel, 0);
        rd(0, 101);
        rd(29, 130);

        // Test 4: out-of-range read, then out-of-range write
        rd(30, 0);
        check("t4_rd_err", err, 1);
        pulse_seq_rst();
        check("t4_clear_err", err, 0);
        check("t4_clear_sel", bank_sel, 0);
        rd(0, 0);
        fill(1);
        check("t4_no_err_yet", err, 0);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(6);
        wr_data  = '1;
        tick();
        wr_valid = 1'b0;
        check("t4_wr_err", err, 1);
        step();
        rd(0, 1);
        rd(29, 30);
        pulse_seq_rst();
        check("t4_seq_rst_err", err, 0);

        // Test 5: abort mid-drain, with a double swap request first
        fill(1);
        step();
`ifdef LSTM_H_DRAIN_EN
        for (int c = 0; c < ALL; c++) dr_q.push_back(D_WL'(c + 1));
        drain(-1, 1, 2, 4, 1'b1);
`else
        check("t5_sel_before", bank_sel, 1);
        pulse_seq_rst();
        check("t5_sel_after", bank_sel, 0);
`endif
        rd(0, 0);
        rd(29, 0);

        // Test 6: write and swap in the same cycle, read in the swap cycle sees old bank
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(10);
        rd_q.push_back('0);
        wg(2, 7, 0, 1'b1);
        rd_en = 1'b0;
        check("t6_bank_sel", bank_sel, 1);
        rd(10, 7);
        rd(14, 7);
        rd(9, 0);
        rd(15, 0);

        repeat (3) tick();
        check("final_rd_q_empty", rd_q.size(), 0);
        check("final_dr_q_empty", dr_q.size(), 0);
        check("final_err", err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
